// File: rtl/sha_sched_pkg.sv
// Shared types and helpers for the SHA work scheduler.
// The SHA midstate bundle is kept here so the scheduler slice stands alone.
package sha_sched_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned STATE_W = 8 * WORD_W;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } sched_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [WORD_W-1:0] c;
      logic [WORD_W-1:0] d;
      logic [WORD_W-1:0] e;
      logic [WORD_W-1:0] f;
      logic [WORD_W-1:0] g;
      logic [WORD_W-1:0] h;
   } hash_state_t;

   // Timer holds PIPELINE_LATENCY-1 at most; keep at least one bit.
   function automatic int unsigned drain_width(input int unsigned lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/sha_sched_drain_timer.sv
// Loadable saturating down-counter with a zero flag; tracks cycles since the
// last core_valid so the scheduler knows when the pipeline is empty.
module sha_sched_drain_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sha_work_scheduler.sv
// Feeds host jobs into a pipelined SHA core: newblock, one valid per nonce, drain.
// Optional performance counters are enabled with `define SHA_SCHED_PERF_EN.
module sha_work_scheduler
   import sha_sched_pkg::*;
#(
   parameter int unsigned PROCESSORINDEX   = 0,
   parameter int unsigned NUMPROCESSORS    = 1,
   parameter int unsigned PIPELINE_LATENCY = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              work_valid,
   output logic              work_ready,
   input  hash_state_t       work_state,
   input  logic [WORD_W-1:0] work_w1,
   input  logic [WORD_W-1:0] work_w2,
   input  logic [WORD_W-1:0] work_w3,
   input  logic [WORD_W-1:0] work_iters,
   input  logic              abort,
   input  logic              stall,
   output logic              core_valid,
   output logic              core_newblock,
   output hash_state_t       core_state,
   output logic [WORD_W-1:0] core_w1,
   output logic [WORD_W-1:0] core_w2,
   output logic [WORD_W-1:0] core_w3,
   output logic [WORD_W-1:0] nonce_o,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] issued_count,
   output logic [WORD_W-1:0] perf_stalls,
   output logic [WORD_W-1:0] perf_jobs
);

   localparam int unsigned      DW         = drain_width(PIPELINE_LATENCY);
   localparam logic [DW-1:0]     DRAIN_LOAD = DW'(PIPELINE_LATENCY - 1);
   localparam logic [WORD_W-1:0] NONCE_BASE = WORD_W'(PROCESSORINDEX);
   localparam logic [WORD_W-1:0] NONCE_STEP = WORD_W'(NUMPROCESSORS);

   sched_state_e      state_q, state_d;
   hash_state_t       hstate_q, hstate_d;
   logic [WORD_W-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
   logic [WORD_W-1:0] iters_q, iters_d;
   logic [WORD_W-1:0] next_nonce_q, next_nonce_d;
   logic [WORD_W-1:0] nonce_q, nonce_d;
   logic [WORD_W-1:0] issued_q, issued_d;
   logic              valid_q, valid_d;
   logic              newblock_q, newblock_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              issue;
   logic              timer_zero_c;
   logic [WORD_W-1:0] cnt_base, nonce_base;

   always_comb begin
      state_d      = state_q;
      hstate_d     = hstate_q;
      w1_d         = w1_q;
      w2_d         = w2_q;
      w3_d         = w3_q;
      iters_d      = iters_q;
      next_nonce_d = next_nonce_q;
      nonce_d      = nonce_q;
      issued_d     = issued_q;
      valid_d      = 1'b0;
      newblock_d   = 1'b0;
      done_d       = 1'b0;
      issue        = 1'b0;
      cnt_base     = issued_q;
      nonce_base   = next_nonce_q;

      case (state_q)
         IDLE: begin
            if (work_valid) begin
               hstate_d     = work_state;
               w1_d         = work_w1;
               w2_d         = work_w2;
               w3_d         = work_w3;
               iters_d      = work_iters;
               issued_d     = '0;
               next_nonce_d = NONCE_BASE;
               nonce_d      = NONCE_BASE;
               cnt_base     = '0;
               nonce_base   = NONCE_BASE;
               if (work_iters == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ISSUE;
                  issue   = !stall;
               end
            end
         end
         ISSUE: begin
            if (abort) begin
               // Pipeline already empty: finish without a drain phase.
               if (timer_zero_c) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               issue = !stall;
            end
         end
         DRAIN: begin
            if (timer_zero_c) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         valid_d      = 1'b1;
         newblock_d   = (cnt_base == '0);
         nonce_d      = nonce_base;
         next_nonce_d = nonce_base + NONCE_STEP;
         issued_d     = cnt_base + WORD_W'(1);
         if (issued_d == iters_d) begin
            state_d = DRAIN;
         end
      end

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hstate_q     <= '0;
         w1_q         <= '0;
         w2_q         <= '0;
         w3_q         <= '0;
         iters_q      <= '0;
         next_nonce_q <= '0;
         nonce_q      <= '0;
         issued_q     <= '0;
         valid_q      <= 1'b0;
         newblock_q   <= 1'b0;
         done_q       <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hstate_q     <= hstate_d;
         w1_q         <= w1_d;
         w2_q         <= w2_d;
         w3_q         <= w3_d;
         iters_q      <= iters_d;
         next_nonce_q <= next_nonce_d;
         nonce_q      <= nonce_d;
         issued_q     <= issued_d;
         valid_q      <= valid_d;
         newblock_q   <= newblock_d;
         done_q       <= done_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
      end
   end

   // Reloaded on every issue, so it reaches zero PIPELINE_LATENCY-1 cycles
   // after the last core_valid cycle; done follows one cycle later.
   sha_sched_drain_timer #(.W(DW)) u_drain_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (issue),
      .load_val (DRAIN_LOAD),
      .zero_c   (timer_zero_c)
   );

`ifdef SHA_SCHED_PERF_EN
   logic [WORD_W-1:0] perf_stalls_q, perf_stalls_d;
   logic [WORD_W-1:0] perf_jobs_q, perf_jobs_d;
   logic              stall_ev;

   // The acceptance cycle is the first issue opportunity, so a stall there counts.
   always_comb begin
      stall_ev      = stall & ((state_q == ISSUE) |
                               ((state_q == IDLE) & work_valid & (work_iters != '0)));
      perf_stalls_d = perf_stalls_q;
      perf_jobs_d   = perf_jobs_q;
      if (stall_ev && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + WORD_W'(1);
      if (done_q && (perf_jobs_q != '1))     perf_jobs_d   = perf_jobs_q + WORD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stalls_q <= '0;
         perf_jobs_q   <= '0;
      end else begin
         perf_stalls_q <= perf_stalls_d;
         perf_jobs_q   <= perf_jobs_d;
      end
   end

   assign perf_stalls = perf_stalls_q;
   assign perf_jobs   = perf_jobs_q;
`else
   assign perf_stalls = '0;
   assign perf_jobs   = '0;
`endif

   assign work_ready    = ready_q;
   assign core_valid    = valid_q;
   assign core_newblock = newblock_q;
   assign core_state    = hstate_q;
   assign core_w1       = w1_q;
   assign core_w2       = w2_q;
   assign core_w3       = w3_q;
   assign nonce_o       = nonce_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign issued_count  = issued_q;

endmodule

// File: tb/tb_sha_work_scheduler.sv
// Directed bench for sha_work_scheduler: two instances share stimulus and
// differ only in nonce offset/stride.
module tb_sha_work_scheduler;
   import sha_sched_pkg::*;

   localparam int unsigned LAT = 4;
   localparam logic [255:0] HS_VAL = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
   localparam logic [31:0]  W1 = 32'hdeadbeef, W2 = 32'h12345678, W3 = 32'hcafef00d;

   logic        clk = 1'b0;
   logic        rst, work_valid, abort, stall;
   hash_state_t work_state;
   logic [31:0] work_w1, work_w2, work_w3, work_iters;

   logic        a_ready, a_valid, a_nb, a_busy, a_done;
   hash_state_t a_state;
   logic [31:0] a_w1, a_w2, a_w3, a_nonce, a_issued, a_pstalls, a_pjobs;
   logic        b_ready, b_valid, b_nb, b_busy, b_done;
   hash_state_t b_state;
   logic [31:0] b_w1, b_w2, b_w3, b_nonce, b_issued, b_pstalls, b_pjobs;

   always #5 clk = ~clk;

   sha_work_scheduler #(.PROCESSORINDEX(0), .NUMPROCESSORS(1), .PIPELINE_LATENCY(LAT)) u_dut_a (
      .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(a_ready),
      .work_state(work_state), .work_w1(work_w1), .work_w2(work_w2), .work_w3(work_w3),
      .work_iters(work_iters), .abort(abort), .stall(stall),
      .core_valid(a_valid), .core_newblock(a_nb), .core_state(a_state),
      .core_w1(a_w1), .core_w2(a_w2), .core_w3(a_w3), .nonce_o(a_nonce),
      .busy(a_busy), .done(a_done), .issued_count(a_issued),
      .perf_stalls(a_pstalls), .perf_jobs(a_pjobs));

   sha_work_scheduler #(.PROCESSORINDEX(2), .NUMPROCESSORS(4), .PIPELINE_LATENCY(LAT)) u_dut_b (
      .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(b_ready),
      .work_state(work_state), .work_w1(work_w1), .work_w2(work_w2), .work_w3(work_w3),
      .work_iters(work_iters), .abort(abort), .stall(stall),
      .core_valid(b_valid), .core_newblock(b_nb), .core_state(b_state),
      .core_w1(b_w1), .core_w2(b_w2), .core_w3(b_w3), .nonce_o(b_nonce),
      .busy(b_busy), .done(b_done), .issued_count(b_issued),
      .perf_stalls(b_pstalls), .perf_jobs(b_pjobs));

   int checks = 0;
   int errors = 0;

   int          r_nvalid, r_nbc, r_first_nb, r_last_v, r_done_c, r_ready;
   logic [31:0] r_na[16];
   logic [31:0] r_nb[16];
   int          bad_valid, bad_done;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Offer one job in cycle 0 and observe until done (bounded); c counts cycles after acceptance.
   task automatic run_job(input logic [31:0] iters, input logic [15:0] stall_mask, input int abort_cyc);
      r_nvalid = 0; r_nbc = 0; r_first_nb = 0; r_last_v = -1; r_done_c = -1; r_ready = 0;
      for (int i = 0; i < 16; i++) begin
         r_na[i] = '1;
         r_nb[i] = '1;
      end
      work_valid = 1'b1;
      work_iters = iters;
      stall      = stall_mask[0];
      abort      = (abort_cyc == 0);
      tick();
      work_valid = 1'b0;
      for (int c = 1; c < 300; c++) begin
         if (a_valid) begin
            if (r_nvalid < 16) begin
               r_na[r_nvalid] = a_nonce;
               r_nb[r_nvalid] = b_nonce;
            end
            if (r_nvalid == 0) r_first_nb = int'(a_nb);
            r_nvalid++;
            r_nbc += int'(a_nb);
            r_last_v = c;
         end
         if (a_done) begin
            r_done_c = c;
            r_ready  = int'(a_ready);
            break;
         end
         stall = (c < 16) && stall_mask[c];
         abort = (c == abort_cyc);
         tick();
      end
      stall = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      work_state = hash_state_t'(HS_VAL);
      work_w1 = W1; work_w2 = W2; work_w3 = W3;
      work_iters = '0; work_valid = 1'b0; abort = 1'b0; stall = 1'b0;
      rst = 1'b1;
      tick(); tick();

      check("rst_valid", a_valid, 0);
      check("rst_ready", a_ready, 1);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_nonce", a_nonce, 0);
      check("rst_issued", a_issued, 0);
      check("rst_state", a_state, 0);
      check("rst_w1", a_w1, 0);
      check("rst_perf_jobs", a_pjobs, 0);
      rst = 1'b0;
      tick();

      // Basic job: 3 nonces, latency 4
      run_job(32'd3, 16'h0, -1);
      check("t1_nvalid", r_nvalid, 3);
      check("t1_newblock_first", r_first_nb, 1);
      check("t1_newblock_count", r_nbc, 1);
      check("t1_last_valid", r_last_v, 3);
      check("t1_done_cycle", r_done_c, 7);
      check("t1_ready_at_done", r_ready, 1);
      check("t1_nonce0", r_na[0], 0);
      check("t1_nonce1", r_na[1], 1);
      check("t1_nonce2", r_na[2], 2);
      check("t2_nonce0", r_nb[0], 2);
      check("t2_nonce1", r_nb[1], 6);
      check("t2_nonce2", r_nb[2], 10);
      check("t2_issued", b_issued, 3);
      check("t1_core_state", a_state, HS_VAL);
      check("t1_core_w1", a_w1, W1);
      check("t1_core_w3", a_w3, W3);
      tick();
      check("t1_done_pulse", a_done, 0);

      // Two stall cycles before the first issue
      run_job(32'd4, 16'h0003, -1);
      check("t3_nvalid", r_nvalid, 4);
      check("t3_newblock_first", r_first_nb, 1);
      check("t3_newblock_count", r_nbc, 1);
      check("t3_last_valid", r_last_v, 6);
      check("t3_done_cycle", r_done_c, 10);
      tick();

`ifdef SHA_SCHED_PERF_EN
      check("perf_jobs", a_pjobs, 2);
      check("perf_stalls", a_pstalls, 2);
`else
      check("perf_jobs_off", a_pjobs, 0);
      check("perf_stalls_off", a_pstalls, 0);
`endif

      // Abort after the fifth valid, then a fresh job
      run_job(32'd100, 16'h0, 5);
      check("t4_nvalid", r_nvalid, 5);
      check("t4_last_valid", r_last_v, 5);
      check("t4_done_cycle", r_done_c, 9);
      run_job(32'd2, 16'h0, -1);
      check("t4b_newblock_first", r_first_nb, 1);
      check("t4b_nonce_a", r_na[0], 0);
      check("t4b_nonce_b", r_nb[0], 2);
      check("t4b_nvalid", r_nvalid, 2);
      check("t4b_done_cycle", r_done_c, 6);
      tick();

      // Zero-iteration job
      run_job(32'd0, 16'h0, -1);
      check("t5_nvalid", r_nvalid, 0);
      check("t5_done_cycle", r_done_c, 1);
      check("t5_ready", r_ready, 1);
      tick();

      // Reset in the middle of ISSUE
      work_valid = 1'b1;
      work_iters = 32'd10;
      tick();
      work_valid = 1'b0;
      tick(); tick();
      check("t5r_mid_valid", a_valid, 1);
      check("t5r_mid_busy", a_busy, 1);
      rst = 1'b1;
      tick();
      check("t5r_valid", a_valid, 0);
      check("t5r_newblock", a_nb, 0);
      check("t5r_busy", a_busy, 0);
      check("t5r_ready", a_ready, 1);
      check("t5r_nonce", a_nonce, 0);
      check("t5r_issued", a_issued, 0);
      check("t5r_state", a_state, 0);
      check("t5r_done", a_done, 0);
      rst = 1'b0;
      bad_valid = 0;
      bad_done  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         bad_valid += int'(a_valid);
         bad_done  += int'(a_done);
      end
      check("t5r_no_valid_after", bad_valid, 0);
      check("t5r_no_done_after", bad_done, 0);
`ifndef SHA_SCHED_PERF_EN
      check("perf_stalls_off_end", b_pstalls, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha_work_scheduler.md
Name: sha_work_scheduler

Overview:
Sequences work units into one pipelined SHA core (the pre-pipeline plus round stages).
- Accepts a job from the host via valid/ready: midstate plus header words w1..w3 and a nonce-iteration count.
- Drives the core input bundle: one newblock cycle, then back-to-back valid cycles, one per nonce.
- Tracks the core's fixed latency and pulses done once the last issued nonce has left the core.

Parameters:
PROCESSORINDEX, 0, starting nonce offset; must equal the core's PROCESSORINDEX.
NUMPROCESSORS, 1, nonce stride; must equal the core's NUMPROCESSORS.
PIPELINE_LATENCY, 64, cycles from a core_valid input to its result at the core output; must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
work_valid  in  1  job offered
work_ready  out  1  scheduler can accept a job
work_state  in  256  midstate (HashState, packed)
work_w1, work_w2, work_w3  in  32 each  header words
work_iters  in  32  number of nonces to issue
abort  in  1  stop issuing the current job
stall  in  1  downstream hold-off; no issue in the following cycle
core_valid  out  1  to core in.valid
core_newblock  out  1  to core in.newblock
core_state  out  256  to core state input
core_w1, core_w2, core_w3  out  32 each  to core in.w1..w3
nonce_o  out  32  nonce carried by the current core_valid cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
issued_count  out  32  valid cycles issued for the current job
perf_stalls  out  32  stall cycles seen in ISSUE (see Optional Feature)
perf_jobs  out  32  jobs completed (see Optional Feature)

Behaviour:
- Reset:
  - state=IDLE; work_ready=1.
  - core_valid, core_newblock, done, busy = 0.
  - core_state, core_w*, nonce_o, issued_count, perf counters = 0.
- All core_* outputs are registered.
- core_state and core_w* hold the latched job values from acceptance until the next acceptance.
- IDLE:
  - work_ready=1; a job is accepted when work_valid & work_ready at cycle T.
  - On acceptance: latch state, w1..w3 and iters; clear issued_count; nonce=PROCESSORINDEX.
  - If iters==0: done pulses at T+1, stay IDLE, no core_valid.
  - Otherwise go to ISSUE at T+1.
- ISSUE:
  - work_ready=0.
  - In each cycle t with !stall(t) & !abort(t): core_valid=1 at t+1.
  - core_newblock=1 only on the first issued cycle of the job. If stall is high, the pending newblock is held until the first real issue.
  - nonce_o on each issued cycle = PROCESSORINDEX + k*NUMPROCESSORS, where k is the issue index; wraps mod 2^32. This matches the core's internal counter.
  - issued_count increments per issue.
  - After the issue with issued_count==iters, go to DRAIN.
- abort in ISSUE: no further core_valid; go to DRAIN. Issued nonces still drain. abort is ignored in IDLE and DRAIN.
- DRAIN:
  - Load the drain timer with PIPELINE_LATENCY and decrement each cycle.
  - When the timer reaches 0: done=1 for one cycle, return to IDLE, work_ready=1 in the same cycle.
- Timing: done rises exactly PIPELINE_LATENCY cycles after the cycle carrying the last core_valid. stall has no effect in DRAIN.
- Simultaneous stall and abort: abort wins; no issue.
- work_valid while busy is ignored; the host holds its data.
- rst mid-job: immediate return to reset values; no done pulse.

Optional Feature:
SHA_SCHED_PERF_EN
- Defined:
  - perf_stalls counts cycles in ISSUE with stall=1.
  - perf_jobs counts done pulses.
  - Both counters saturate at 2^32-1 and clear only on rst.
- Undefined: perf_stalls and perf_jobs are tied to 0 and no counter logic is synthesized.

Decomposition:
- Package sha_sched_pkg:
  - enum sched_state_e {IDLE, ISSUE, DRAIN}.
  - Function drain_width(PIPELINE_LATENCY), using $clog2.
  - HashState is imported from the existing shared SHA package.
- Sub-module sha_sched_drain_timer: loadable down-counter with zero flag, used for DRAIN.

Test Plan:
1. PROCESSORINDEX=0, NUMPROCESSORS=1, PIPELINE_LATENCY=4. Job iters=3 accepted at T -> core_valid at T+1..T+3; core_newblock only at T+1; nonce_o = 0,1,2; done at T+7; work_ready=1 at T+7.
2. PROCESSORINDEX=2, NUMPROCESSORS=4, iters=3 -> nonce_o = 2,6,10; issued_count ends at 3.
3. iters=4, stall high for 2 cycles before the first issue -> the first core_valid has core_newblock=1; 4 valids total; done is delayed 2 cycles versus no-stall.
4. iters=100, abort raised after 5 issues -> exactly 5 core_valid; done 4 cycles after the 5th valid; a second job is then accepted and its first cycle has newblock=1, nonce_o=PROCESSORINDEX.
5. iters=0 -> no core_valid, done at T+1. Separately, rst mid-ISSUE -> all outputs return to reset values next cycle and there is no done pulse.
6. With SHA_SCHED_PERF_EN defined, run scenarios 1 and 3 -> perf_jobs=2, perf_stalls=2. Without the macro, both outputs are constant 0.
